// File: rtl/mlab_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mlab_ram_arbiter
// Description : Round-robin arbiter and clear-sweep sequencer sharing one
//               single-port MLAB RAM (async read, sync write) between two
//               requesters A and B.
// Revision    : 1.0 - initial release
// ============================================================================
module mlab_ram_arbiter #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDR_WIDTH    = 6,
   parameter bit                    INIT_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req,
   output logic                  init_busy,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_write,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t                c_reset_state = INIT_ON_RESET ? ST_INIT : ST_RUN;
   localparam logic [ADDR_WIDTH-1:0] c_cnt_one     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] c_cnt_last    = '1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   // 1 when B holds the most recent transfer, so A wins the next contention
   logic                    last_b_q, last_b_d;
   logic                    a_rvalid_q, a_rvalid_d;
   logic                    b_rvalid_q, b_rvalid_d;
   logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;

   assign init_busy = (state_q == ST_INIT);
   assign a_rvalid  = a_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;

   // Grant decision: clear request blocks all grants; contention alternates
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if ((state_q == ST_RUN) && !clear_req) begin
         if (a_req && b_req) begin
            a_gnt = last_b_q;
            b_gnt = !last_b_q;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   // RAM port mux: sweep writes in INIT, granted requester in RUN, idle zeros otherwise
   always_comb begin
      ram_addr    = '0;
      ram_data_in = '0;
      ram_write   = 1'b0;
      if (state_q == ST_INIT) begin
         ram_addr    = cnt_q;
         ram_data_in = INIT_VALUE;
         ram_write   = 1'b1;
      end else if (a_gnt) begin
         ram_addr    = a_addr;
         ram_data_in = a_wdata;
         ram_write   = a_we;
      end else if (b_gnt) begin
         ram_addr    = b_addr;
         ram_data_in = b_wdata;
         ram_write   = b_we;
      end
   end

   // Next-state: sweep counter, state transitions, last-grant and read capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_b_d   = last_b_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      // A grant only exists with its request, so gnt & ~we marks a read transfer
      a_rvalid_d = a_gnt && !a_we;
      b_rvalid_d = b_gnt && !b_we;
      if (a_rvalid_d) begin
         a_rdata_d = ram_data_out;
      end
      if (b_rvalid_d) begin
         b_rdata_d = ram_data_out;
      end
      if (a_gnt) begin
         last_b_d = 1'b0;
      end else if (b_gnt) begin
         last_b_d = 1'b1;
      end
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + c_cnt_one;
         if (cnt_q == c_cnt_last) begin
            state_d = ST_RUN;
         end
      end else if (clear_req) begin
         state_d = ST_INIT;
         cnt_d   = '0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= c_reset_state;
         cnt_q      <= '0;
         last_b_q   <= 1'b1;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_b_q   <= last_b_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mlab_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlab_ram_arbiter
// Description : Directed self-checking bench for mlab_ram_arbiter with a
//               behavioural async-read / sync-write RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlab_ram_arbiter;

   logic       clk;
   logic       rst_n;
   logic       clear_req;
   logic       init_busy;
   logic       a_req, a_we, a_gnt, a_rvalid;
   logic [5:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic       b_req, b_we, b_gnt, b_rvalid;
   logic [5:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic [5:0] ram_addr;
   logic [7:0] ram_data_in;
   logic       ram_write;
   logic [7:0] ram_data_out;

   logic [7:0] mem [64];

   int n_checks;
   int n_fail;

   mlab_ram_arbiter #(
      .DATA_WIDTH   (8),
      .ADDR_WIDTH   (6),
      .INIT_ON_RESET(1'b1),
      .INIT_VALUE   (8'h00)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_req   (clear_req),
      .init_busy   (init_busy),
      .a_req       (a_req),
      .a_we        (a_we),
      .a_addr      (a_addr),
      .a_wdata     (a_wdata),
      .a_gnt       (a_gnt),
      .a_rvalid    (a_rvalid),
      .a_rdata     (a_rdata),
      .b_req       (b_req),
      .b_we        (b_we),
      .b_addr      (b_addr),
      .b_wdata     (b_wdata),
      .b_gnt       (b_gnt),
      .b_rvalid    (b_rvalid),
      .b_rdata     (b_rdata),
      .ram_addr    (ram_addr),
      .ram_data_in (ram_data_in),
      .ram_write   (ram_write),
      .ram_data_out(ram_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, asynchronous read
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_data_in;
   end
   assign ram_data_out = mem[ram_addr];

   // A requester must not change its command while waiting for a grant
   logic        a_pend, b_pend;
   logic [14:0] a_hold, b_hold;
   always @(posedge clk) begin
      if (a_pend && a_req)
         assert ({a_we, a_addr, a_wdata} == a_hold) else $error("A command changed while pending");
      if (b_pend && b_req)
         assert ({b_we, b_addr, b_wdata} == b_hold) else $error("B command changed while pending");
      a_pend <= rst_n && a_req && !a_gnt;
      b_pend <= rst_n && b_req && !b_gnt;
      a_hold <= {a_we, a_addr, a_wdata};
      b_hold <= {b_we, b_addr, b_wdata};
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered on a falling edge with the sweep running; returns cycles spent busy
   task automatic run_sweep(output int n);
      n = 0;
      #1;
      while (init_busy && n < 200) begin
         chk_eq("sweep_addr",  {26'd0, ram_addr}, n);
         chk_eq("sweep_write", {31'd0, ram_write}, 1);
         chk_eq("sweep_data",  {24'd0, ram_data_in}, 0);
         chk_eq("sweep_gnt",   {30'd0, a_gnt, b_gnt}, 0);
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   task automatic chk_mem_clear(input string tag);
      logic [7:0] acc;
      acc = 8'h00;
      for (int i = 0; i < 64; i++) acc = acc | mem[i];
      chk_eq(tag, {24'd0, acc}, 0);
   endtask

   initial begin
      int n;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      clear_req = 1'b0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 64; i++) mem[i] = 8'hA5;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk_eq("rst_busy",     {31'd0, init_busy}, 1);
      chk_eq("rst_rvalid",   {30'd0, a_rvalid, b_rvalid}, 0);
      chk_eq("rst_rdata",    {16'd0, a_rdata, b_rdata}, 0);
      chk_eq("rst_ram_addr", {26'd0, ram_addr}, 0);

      // 1: sweep after reset release, A request ignored throughout
      a_req = 1'b1; a_addr = 6'd5;
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(n);
      a_req = 1'b0;
      chk_eq("t1_sweep_len", n, 64);
      chk_mem_clear("t1_mem_clear");

      // 3: both read, held 4 cycles -> A,B,A,B
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd1;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk_eq("t3_a_gnt", {31'd0, a_gnt}, (k % 2 == 0) ? 1 : 0);
         chk_eq("t3_b_gnt", {31'd0, b_gnt}, (k % 2 == 1) ? 1 : 0);
         if (k > 0) chk_eq("t3_a_rvalid", {31'd0, a_rvalid}, (k % 2 == 1) ? 1 : 0);
         @(negedge clk);
      end
      a_req = 1'b0; b_req = 1'b0;
      #1;
      chk_eq("t3_b_rvalid_last", {31'd0, b_rvalid}, 1);
      chk_eq("t3_a_rvalid_last", {31'd0, a_rvalid}, 0);

      // 2: A write 0x5A@3 then read @3
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'd3; a_wdata = 8'h5A;
      #1;
      chk_eq("t2_wr_gnt",   {31'd0, a_gnt}, 1);
      chk_eq("t2_wr_drive", {ram_write, 17'd0, ram_addr, ram_data_in}, {1'b1, 17'd0, 6'd3, 8'h5A});
      @(negedge clk);
      a_we = 1'b0;
      #1;
      chk_eq("t2_rd_gnt",   {31'd0, a_gnt}, 1);
      chk_eq("t2_rd_write", {31'd0, ram_write}, 0);
      chk_eq("t2_rvalid_early", {31'd0, a_rvalid}, 0);
      @(negedge clk);
      a_req = 1'b0;
      #1;
      chk_eq("t2_a_rvalid", {31'd0, a_rvalid}, 1);
      chk_eq("t2_a_rdata",  {24'd0, a_rdata}, 32'h5A);
      chk_eq("t2_b_rvalid", {31'd0, b_rvalid}, 0);
      @(negedge clk);
      #1;
      chk_eq("t2_rvalid_drop", {31'd0, a_rvalid}, 0);
      chk_eq("t2_rdata_held",  {24'd0, a_rdata}, 32'h5A);

      // 4: B write 0x11@7 contends with A read @7; B wins (A was last)
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd7;
      b_req = 1'b1; b_we = 1'b1; b_addr = 6'd7; b_wdata = 8'h11;
      #1;
      chk_eq("t4_first_gnt", {30'd0, a_gnt, b_gnt}, 1);
      @(negedge clk);
      b_req = 1'b0;
      #1;
      chk_eq("t4_second_gnt", {30'd0, a_gnt, b_gnt}, 2);
      @(negedge clk);
      a_req = 1'b0;
      #1;
      chk_eq("t4_a_rvalid", {31'd0, a_rvalid}, 1);
      chk_eq("t4_a_rdata",  {24'd0, a_rdata}, 32'h11);

      // 5: clear_req while A read held -> 65 cycles without grant, then INIT_VALUE
      @(negedge clk);
      clear_req = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3;
      #1;
      chk_eq("t5_clear_gnt",   {30'd0, a_gnt, b_gnt}, 0);
      chk_eq("t5_clear_write", {31'd0, ram_write}, 0);
      n = 0;
      while (!a_gnt && n < 200) begin
         n++;
         @(negedge clk);
         clear_req = 1'b0;
         #1;
      end
      chk_eq("t5_no_gnt_cycles", n, 65);
      @(negedge clk);
      a_req = 1'b0;
      #1;
      chk_eq("t5_a_rvalid", {31'd0, a_rvalid}, 1);
      chk_eq("t5_a_rdata",  {24'd0, a_rdata}, 0);
      chk_mem_clear("t5_mem_clear");

      // 6a: reset in the cycle a read result is pending drops rvalid
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'd9; a_wdata = 8'h3C;
      @(negedge clk);
      a_we = 1'b0;
      #1;
      chk_eq("t6_rd_gnt", {31'd0, a_gnt}, 1);
      @(posedge clk);
      #1;
      chk_eq("t6_pre_rvalid", {31'd0, a_rvalid}, 1);
      chk_eq("t6_pre_rdata",  {24'd0, a_rdata}, 32'h3C);
      rst_n = 1'b0;
      a_req = 1'b0;
      #1;
      chk_eq("t6_rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
      chk_eq("t6_rst_rdata",  {24'd0, a_rdata}, 0);
      chk_eq("t6_rst_busy",   {31'd0, init_busy}, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(n);
      chk_eq("t6_sweep_len", n, 64);

      // 6b: reset mid-sweep at address 20 restarts the sweep from 0
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      n = 0;
      while (ram_addr != 6'd20 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_eq("t6_reach_addr20", n, 20);
      rst_n = 1'b0;
      #1;
      chk_eq("t6_mid_addr",   {26'd0, ram_addr}, 0);
      chk_eq("t6_mid_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
      chk_eq("t6_mid_rdata",  {16'd0, a_rdata, b_rdata}, 0);
      chk_eq("t6_mid_busy",   {31'd0, init_busy}, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(n);
      chk_eq("t6_restart_len", n, 64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
